// File: rtl/shift_sequencer_if.sv
// Request/response bundle for shift_sequencer.
// The master drives the operand and shift request; the slave returns busy/done, the result and flags.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic [1:0]       shift;
  logic [CNT_W-1:0] amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  modport master (
    output start, value, shift, amount,
    input  busy, done, result, carry_out, zero
  );

  modport slave (
    input  start, value, shift, amount,
    output busy, done, result, carry_out, zero
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one 1-bit shift per clock, result returned with a one-cycle done pulse.
// Optional result flags (carry_out, zero) are enabled by defining SHIFT_SEQ_FLAGS_EN.
module shift_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input logic               clk,
  input logic               reset,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] step_data;
  logic             direct_done;
  logic             last_step;

  // Single 1-bit step of the current operation.
  always_comb begin
    step_data = data_q;
    case (op_q)
      2'b01:   step_data = {data_q[WIDTH-2:0], 1'b0};
      2'b10:   step_data = {1'b0, data_q[WIDTH-1:1]};
      2'b11:   step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      default: step_data = data_q;
    endcase
  end

  assign direct_done = (bus.amount == '0) || (bus.shift == 2'b00);
  assign last_step   = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      data_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            data_q <= bus.value;
            op_q   <= bus.shift;
            cnt_q  <= bus.amount;
            busy_q <= 1'b1;
            if (direct_done) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= bus.value;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          data_q <= step_data;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (last_step) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            result_q <= step_data;
          end
        end
        StDone: begin
          // Any start seen here is dropped; a new request is taken once back in idle.
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

`ifdef SHIFT_SEQ_FLAGS_EN
  logic carry_q;
  logic zero_q;
  logic step_carry;

  assign step_carry = (op_q == 2'b01) ? data_q[WIDTH-1] : data_q[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == StIdle && bus.start && direct_done) begin
      carry_q <= 1'b0;
      zero_q  <= (bus.value == '0);
    end else if (state_q == StShift && last_step) begin
      carry_q <= step_carry;
      zero_q  <= (step_data == '0);
    end
  end

  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;
`else
  assign bus.carry_out = 1'b0;
  assign bus.zero      = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and random checks of shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  int   n_fail;
  logic [15:0] last_r;

  shift_sequencer_if #(.WIDTH(16), .CNT_W(4)) sif ();

  shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_res(input logic [15:0] v, input logic [1:0] sh,
                                            input int n);
    logic [15:0] r;
    case (sh)
      2'b01:   r = v << n;
      2'b10:   r = v >> n;
      2'b11:   r = 16'($signed(v) >>> n);
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic model_carry(input logic [15:0] v, input logic [1:0] sh, input int n);
    if (n == 0 || sh == 2'b00) return 1'b0;
    if (sh == 2'b01) return v[16-n];
    return v[n-1];
  endfunction

  // Issue one request and follow it cycle by cycle to the done pulse and back to idle.
  task automatic run_op(input logic [15:0] v, input logic [1:0] sh, input int n,
                        input bit glitch);
    logic [15:0] exp_r;
    logic        exp_c;
    logic        exp_z;
    int          d;
    exp_r = model_res(v, sh, n);
`ifdef SHIFT_SEQ_FLAGS_EN
    exp_c = model_carry(v, sh, n);
    exp_z = (exp_r == 16'h0);
`else
    exp_c = 1'b0;
    exp_z = 1'b0;
`endif
    d = (n == 0 || sh == 2'b00) ? 0 : n;
    sif.value  = v;
    sif.shift  = sh;
    sif.amount = 4'(n);
    sif.start  = 1'b1;
    tick();
    sif.start  = 1'b0;
    sif.value  = 16'($urandom);
    sif.shift  = 2'($urandom);
    sif.amount = 4'($urandom);
    for (int i = 0; i <= d; i++) begin
      chk("busy_during_op", 32'(sif.busy), 32'(1'b1));
      chk("done_timing", 32'(sif.done), 32'(i == d));
      if (i < d) begin
        chk("result_held", 32'(sif.result), 32'(last_r));
        if (glitch && i == 0) begin
          sif.start  = 1'b1;
          sif.value  = 16'hFFFF;
          sif.shift  = 2'b01;
          sif.amount = 4'd1;
        end
        tick();
        sif.start = 1'b0;
      end
    end
    chk("result", 32'(sif.result), 32'(exp_r));
    chk("carry_out", 32'(sif.carry_out), 32'(exp_c));
    chk("zero", 32'(sif.zero), 32'(exp_z));
    // A start presented during the done cycle must be dropped.
    sif.start  = glitch;
    sif.value  = 16'hFFFF;
    sif.shift  = 2'b01;
    sif.amount = 4'd1;
    tick();
    sif.start = 1'b0;
    chk("idle_busy", 32'(sif.busy), 32'(1'b0));
    chk("idle_done", 32'(sif.done), 32'(1'b0));
    chk("idle_result", 32'(sif.result), 32'(exp_r));
    last_r = exp_r;
  endtask

  initial begin
    n_total    = 0;
    n_pass     = 0;
    n_fail     = 0;
    last_r     = 16'h0;
    reset      = 1'b1;
    sif.start  = 1'b0;
    sif.value  = 16'h0;
    sif.shift  = 2'b00;
    sif.amount = 4'd0;
    tick();
    tick();
    chk("rst_busy", 32'(sif.busy), 32'(1'b0));
    chk("rst_done", 32'(sif.done), 32'(1'b0));
    chk("rst_result", 32'(sif.result), 32'h0);
    chk("rst_carry", 32'(sif.carry_out), 32'h0);
    chk("rst_zero", 32'(sif.zero), 32'h0);
    reset = 1'b0;
    tick();

    run_op(16'h0001, 2'b01, 3, 1'b0);
    run_op(16'h8000, 2'b11, 4, 1'b0);
    run_op(16'h8000, 2'b10, 4, 1'b0);
    run_op(16'h1234, 2'b01, 0, 1'b0);
    run_op(16'h5A5A, 2'b00, 7, 1'b0);
    run_op(16'h0003, 2'b01, 5, 1'b1);
    run_op(16'hFFFF, 2'b10, 15, 1'b0);
    run_op(16'hFFFF, 2'b01, 15, 1'b1);
    run_op(16'h8001, 2'b01, 1, 1'b0);
    run_op(16'h0001, 2'b10, 1, 1'b0);

    // Reset in the middle of an amount=8 operation.
    sif.value  = 16'h0001;
    sif.shift  = 2'b01;
    sif.amount = 4'd8;
    sif.start  = 1'b1;
    tick();
    sif.start = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(sif.busy), 32'(1'b0));
    chk("midrst_done", 32'(sif.done), 32'(1'b0));
    chk("midrst_result", 32'(sif.result), 32'h0);
    tick();
    reset  = 1'b0;
    last_r = 16'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("postrst_no_done", 32'(sif.done), 32'(1'b0));
    end
    run_op(16'h00F0, 2'b11, 2, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_op(16'($urandom), 2'($urandom), int'($urandom_range(0, 15)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
